// File: rtl/fft_unloader_if.sv
// Output sample stream of the FFT unloader: one complex word per transfer,
// valid/ready handshake, last marks natural-order index N-1.
//   out_real/out_imag : sample payload (master -> slave)
//   out_valid         : payload valid (master -> slave)
//   out_last          : payload is the final sample of the frame (master -> slave)
//   out_ready         : slave accepts the sample (slave -> master)
interface fft_unloader_if #(
    parameter int unsigned DATA_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] out_real;
    logic [DATA_WIDTH-1:0] out_imag;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output out_real,
        output out_imag,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_real,
        input  out_imag,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_unloader.sv
// Reads FFT results out of the A/B memory read ports after the AGU finishes
// and streams them as natural-order complex samples 0..N-1.
//   clk, clr          : clock (rising edge), asynchronous active-high reset
//   start             : begin unload (AGU done); ignored unless idle
//   addr_A_read/B     : memory read addresses for even/odd output index of pair k
//   A_*_in, B_*_in    : synchronous memory read data (one cycle after address)
//   stream            : output sample stream (master side)
//   busy              : unload in progress
//   done              : one-cycle pulse after the last sample is accepted
module fft_unloader #(
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter bit          BIT_REVERSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] addr_A_read,
    output logic [ADDR_WIDTH-1:0] addr_B_read,
    input  logic [DATA_WIDTH-1:0] A_real_in,
    input  logic [DATA_WIDTH-1:0] A_imag_in,
    input  logic [DATA_WIDTH-1:0] B_real_in,
    input  logic [DATA_WIDTH-1:0] B_imag_in,
    fft_unloader_if.master        stream,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned K_W = ADDR_WIDTH - 1;
    localparam logic [K_W-1:0] K_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT_A,
        EMIT_B,
        DONE
    } state_t;

    state_t                state, state_nx;
    logic [K_W-1:0]        k, k_nx, k_inc;
    logic [ADDR_WIDTH-1:0] addr_a, addr_a_nx, addr_b, addr_b_nx;
    logic [DATA_WIDTH-1:0] hold_b_re, hold_b_re_nx, hold_b_im, hold_b_im_nx;
    logic [DATA_WIDTH-1:0] out_re, out_re_nx, out_im, out_im_nx;
    logic                  valid, valid_nx, last, last_nx;
    logic                  busy_q, busy_nx, done_q, done_nx;

    // Output index -> memory address (bit reversal undoes in-place FFT ordering).
    function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] idx);
        logic [ADDR_WIDTH-1:0] r;
        r = idx;
        if (BIT_REVERSE) begin
            for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
                r[i] = idx[int'(ADDR_WIDTH) - 1 - i];
            end
        end
        return r;
    endfunction

    assign k_inc = k + K_W'(1);

    // State and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            k         <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            hold_b_re <= '0;
            hold_b_im <= '0;
            out_re    <= '0;
            out_im    <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            addr_a    <= addr_a_nx;
            addr_b    <= addr_b_nx;
            hold_b_re <= hold_b_re_nx;
            hold_b_im <= hold_b_im_nx;
            out_re    <= out_re_nx;
            out_im    <= out_im_nx;
            valid     <= valid_nx;
            last      <= last_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
        end
    end

    // Next state and next register values. Addresses are loaded on entry to
    // FETCH, so they are on the memory port for the whole FETCH cycle.
    always_comb begin
        state_nx     = state;
        k_nx         = k;
        addr_a_nx    = addr_a;
        addr_b_nx    = addr_b;
        hold_b_re_nx = hold_b_re;
        hold_b_im_nx = hold_b_im;
        out_re_nx    = out_re;
        out_im_nx    = out_im;
        valid_nx     = valid;
        last_nx      = last;
        busy_nx      = busy_q;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = FETCH;
                    k_nx      = '0;
                    addr_a_nx = map_addr(ADDR_WIDTH'(0));
                    addr_b_nx = map_addr(ADDR_WIDTH'(1));
                    busy_nx   = 1'b1;
                end
            end
            FETCH: state_nx = WAIT;
            WAIT: begin
                // A goes straight to the output register, B is parked.
                out_re_nx    = A_real_in;
                out_im_nx    = A_imag_in;
                hold_b_re_nx = B_real_in;
                hold_b_im_nx = B_imag_in;
                valid_nx     = 1'b1;
                last_nx      = 1'b0;
                state_nx     = EMIT_A;
            end
            EMIT_A: begin
                if (stream.out_ready) begin
                    out_re_nx = hold_b_re;
                    out_im_nx = hold_b_im;
                    last_nx   = (k == K_LAST);
                    state_nx  = EMIT_B;
                end
            end
            EMIT_B: begin
                if (stream.out_ready) begin
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    if (k == K_LAST) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end else begin
                        k_nx      = k_inc;
                        addr_a_nx = map_addr({k_inc, 1'b0});
                        addr_b_nx = map_addr({k_inc, 1'b1});
                        state_nx  = FETCH;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign addr_A_read     = addr_a;
    assign addr_B_read     = addr_b;
    assign stream.out_real = out_re;
    assign stream.out_imag = out_im;
    assign stream.out_valid = valid;
    assign stream.out_last = last;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule
